// File: rtl/jts16_pal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jts16_pal_ctrl
// Description : Palette RAM port controller. Owns the single read/write port
//               of the 2048x16 palette RAM on the CPU side of the colour mixer.
//               Sequences CPU reads and writes with a wait/ack handshake and,
//               when built with JTS16_PAL_CLR_EN, runs a background sweep that
//               writes CLR_VAL to every palette entry (boot clear / blackout).
//               The CPU always wins the port; the sweep pauses between words
//               and resumes at the next unwritten address.
// Config      : `define JTS16_PAL_CLR_EN to build the sweep engine. Without
//               it, clr_req_i is ignored and clr_busy_o is tied low.
// Ports       : clk, rst        clock, asynchronous active-high reset
//               pal_cs_i        CPU request (level, held until cpu_ok_o)
//               cpu_rnw_i       1=read 0=write
//               cpu_addr_i      CPU word address
//               cpu_dout_i      CPU write data
//               dsn_i           byte strobes, active low {UDS,LDS}
//               cpu_din_o       read data, valid while cpu_ok_o on reads
//               cpu_ok_o        access complete, held until pal_cs_i falls
//               clr_req_i       sweep start (rising edge)
//               clr_busy_o      sweep in progress
//               ram_addr_o      RAM port address
//               ram_din_o       RAM port write data
//               ram_we_o        RAM byte write enables {hi,lo}
//               ram_q_i         RAM read data, one clock after ram_addr_o
// Revision    : 1.0  initial release
// ============================================================================
module jts16_pal_ctrl #(
    parameter logic [15:0] CLR_VAL = 16'h0000,
    parameter int          AW      = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pal_cs_i,
    input  logic          cpu_rnw_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [15:0]   cpu_dout_i,
    input  logic [1:0]    dsn_i,
    output logic [15:0]   cpu_din_o,
    output logic          cpu_ok_o,
    input  logic          clr_req_i,
    output logic          clr_busy_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [15:0]   ram_din_o,
    output logic [1:0]    ram_we_o,
    input  logic [15:0]   ram_q_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_RD  = 2'd1,
        ST_CPU_ACK = 2'd2
`ifdef JTS16_PAL_CLR_EN
        ,ST_CLR    = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          cpu_ok_q, cpu_ok_d;
    logic [15:0]   cpu_din_q, cpu_din_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]   ram_din_q, ram_din_d;
    logic [1:0]    ram_we_q, ram_we_d;
    logic          rnw_q, rnw_d;

`ifdef JTS16_PAL_CLR_EN
    localparam logic [AW-1:0] c_ptr_last = {AW{1'b1}};
    localparam logic [AW-1:0] c_ptr_one  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic          clr_req_q;
    logic          w_clr_rise;

    assign w_clr_rise = clr_req_i & ~clr_req_q;
`else
    // Sweep inputs have no function in this build.
    logic w_clr_unused;
    assign w_clr_unused = ^{clr_req_i, CLR_VAL};
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cpu_ok_d   = cpu_ok_q;
        cpu_din_d  = cpu_din_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 2'b00;     // write strobes are single-cycle pulses
        rnw_d      = rnw_q;
`ifdef JTS16_PAL_CLR_EN
        ptr_d      = ptr_q;
        busy_d     = busy_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pal_cs_i && !cpu_ok_q) begin
                    ram_addr_d = cpu_addr_i;
                    ram_din_d  = cpu_dout_i;
                    rnw_d      = cpu_rnw_i;
                    if (cpu_rnw_i) begin
                        state_d = ST_CPU_RD;
                    end else begin
                        // dsn=11 still completes, just with no strobe
                        ram_we_d = ~dsn_i;
                        state_d  = ST_CPU_ACK;
                    end
                end
`ifdef JTS16_PAL_CLR_EN
                else if (busy_q) begin
                    state_d = ST_CLR;
                end
`endif
            end
            ST_CPU_RD: begin
                // Address is on the port; RAM data arrives one clock later.
                state_d = ST_CPU_ACK;
            end
            ST_CPU_ACK: begin
                if (!pal_cs_i) begin
                    cpu_ok_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cpu_ok_d = 1'b1;
                    // First ACK cycle of a read: ram_q now holds the word
                    // addressed from IDLE, so capture it alongside cpu_ok.
                    if (rnw_q && !cpu_ok_q) begin
                        cpu_din_d = ram_q_i;
                    end
                end
            end
`ifdef JTS16_PAL_CLR_EN
            ST_CLR: begin
                if (pal_cs_i) begin
                    // Yield between words; ptr already points at the next
                    // unwritten entry, so resuming neither skips nor repeats.
                    state_d = ST_IDLE;
                end else begin
                    ram_addr_d = ptr_q;
                    ram_din_d  = CLR_VAL;
                    ram_we_d   = 2'b11;
                    if (ptr_q == c_ptr_last) begin
                        ptr_d   = '0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + c_ptr_one;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef JTS16_PAL_CLR_EN
        // A new request always restarts from entry 0, even mid-sweep.
        if (w_clr_rise) begin
            busy_d = 1'b1;
            ptr_d  = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cpu_ok_q   <= 1'b0;
            cpu_din_q  <= 16'h0000;
            ram_addr_q <= '0;
            ram_din_q  <= 16'h0000;
            ram_we_q   <= 2'b00;
            rnw_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_ok_q   <= cpu_ok_d;
            cpu_din_q  <= cpu_din_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            rnw_q      <= rnw_d;
        end
    end

`ifdef JTS16_PAL_CLR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            clr_req_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            clr_req_q <= clr_req_i;
        end
    end

    assign clr_busy_o = busy_q;
`else
    assign clr_busy_o = 1'b0;
`endif

    assign cpu_din_o  = cpu_din_q;
    assign cpu_ok_o   = cpu_ok_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_din_o  = ram_din_q;
    assign ram_we_o   = ram_we_q;

endmodule
`default_nettype wire

// File: tb/tb_jts16_pal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jts16_pal_ctrl
// Description : Directed self-checking bench for jts16_pal_ctrl. Models the
//               palette RAM (byte-enabled writes, one-clock read latency) and
//               logs every RAM write for the sweep scenarios, which are built
//               only when JTS16_PAL_CLR_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_jts16_pal_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pal_cs;
    logic        cpu_rnw;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic [1:0]  dsn;
    logic [15:0] cpu_din;
    logic        cpu_ok;
    logic        clr_req;
    logic        clr_busy;
    logic [10:0] ram_addr;
    logic [15:0] ram_din;
    logic [1:0]  ram_we;
    logic [15:0] ram_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jts16_pal_ctrl #(.CLR_VAL(16'h0000), .AW(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .pal_cs_i  (pal_cs),
        .cpu_rnw_i (cpu_rnw),
        .cpu_addr_i(cpu_addr),
        .cpu_dout_i(cpu_dout),
        .dsn_i     (dsn),
        .cpu_din_o (cpu_din),
        .cpu_ok_o  (cpu_ok),
        .clr_req_i (clr_req),
        .clr_busy_o(clr_busy),
        .ram_addr_o(ram_addr),
        .ram_din_o (ram_din),
        .ram_we_o  (ram_we),
        .ram_q_i   (ram_q)
    );

    // ---------------- RAM model and write log ----------------
    logic [15:0] mem  [0:2047];
    int          wcnt [0:2047];
    int          total_writes;
    int          seq_err;
    logic [10:0] exp_next;
    logic        init_mem = 1'b0;
    logic        clr_log  = 1'b0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'hA5A5;
        end else begin
            if (ram_we[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            if (ram_we[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
        end
        ram_q <= mem[ram_addr];
        if (clr_log) begin
            for (int i = 0; i < 2048; i++) wcnt[i] <= 0;
            total_writes <= 0;
            seq_err      <= 0;
            exp_next     <= 11'd0;
        end else if (ram_we != 2'b00) begin
            wcnt[ram_addr] <= wcnt[ram_addr] + 1;
            total_writes   <= total_writes + 1;
            if (ram_addr != exp_next) seq_err <= seq_err + 1;
            exp_next <= ram_addr + 11'd1;
        end
    end

    task automatic reset_log();
        clr_log = 1'b1;
        @(negedge clk);
        clr_log = 1'b0;
    endtask

    // One CPU access from a falling edge; returns observations only.
    task automatic cpu_cycle(input logic rnw, input logic [10:0] a,
                             input logic [15:0] d, input logic [1:0] ds,
                             output int lat, output logic [15:0] rd,
                             output logic [1:0] we1, output logic [10:0] a1,
                             output logic [15:0] d1, output int wecnt,
                             output logic held, output logic ok_after);
        pal_cs = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_dout = d; dsn = ds;
        lat = 0; wecnt = 0; we1 = 2'b00; a1 = '0; d1 = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin we1 = ram_we; a1 = ram_addr; d1 = ram_din; end
            if (ram_we != 2'b00) wecnt++;
        end while (!cpu_ok && lat < 20);
        rd = cpu_din;
        if (!cpu_ok) lat = -1;
        held = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (!cpu_ok || cpu_din !== rd) held = 1'b0;
            if (ram_we != 2'b00) wecnt++;
        end
        pal_cs = 1'b0;
        @(negedge clk);
        ok_after = cpu_ok;
    endtask

    int          lat, wecnt;
    logic [15:0] rd, d1;
    logic [1:0]  we1;
    logic [10:0] a1;
    logic        held, ok_after;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; pal_cs = 1'b0; cpu_rnw = 1'b0; cpu_addr = '0;
        cpu_dout = '0; dsn = 2'b11; clr_req = 1'b0;
        init_mem = 1'b1; clr_log = 1'b1;
        repeat (3) @(negedge clk);
        init_mem = 1'b0; clr_log = 1'b0;
        checks++; if (cpu_ok !== 1'b0)       begin errors++; $display("FAIL reset_cpu_ok got %b exp 0", cpu_ok); end
        checks++; if (cpu_din !== 16'h0000)  begin errors++; $display("FAIL reset_cpu_din got %h exp 0000", cpu_din); end
        checks++; if (clr_busy !== 1'b0)     begin errors++; $display("FAIL reset_clr_busy got %b exp 0", clr_busy); end
        checks++; if (ram_we !== 2'b00)      begin errors++; $display("FAIL reset_ram_we got %b exp 00", ram_we); end
        checks++; if (ram_addr !== 11'h000)  begin errors++; $display("FAIL reset_ram_addr got %h exp 000", ram_addr); end
        checks++; if (ram_din !== 16'h0000)  begin errors++; $display("FAIL reset_ram_din got %h exp 0000", ram_din); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_full();
        cpu_cycle(1'b0, 11'h155, 16'h1234, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (lat != 2)            begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
        checks++; if (we1 !== 2'b11)       begin errors++; $display("FAIL wr_ram_we got %b exp 11", we1); end
        checks++; if (a1 !== 11'h155)      begin errors++; $display("FAIL wr_ram_addr got %h exp 155", a1); end
        checks++; if (d1 !== 16'h1234)     begin errors++; $display("FAIL wr_ram_din got %h exp 1234", d1); end
        checks++; if (wecnt != 1)          begin errors++; $display("FAIL wr_we_pulses got %0d exp 1", wecnt); end
        checks++; if (held !== 1'b1)       begin errors++; $display("FAIL wr_ok_held got %b exp 1", held); end
        checks++; if (ok_after !== 1'b0)   begin errors++; $display("FAIL wr_ok_release got %b exp 0", ok_after); end
        checks++; if (mem[11'h155] !== 16'h1234) begin errors++; $display("FAIL wr_mem got %h exp 1234", mem[11'h155]); end
    endtask

    task automatic test_read();
        cpu_cycle(1'b1, 11'h155, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (lat != 3)            begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
        checks++; if (rd !== 16'h1234)     begin errors++; $display("FAIL rd_data got %h exp 1234", rd); end
        checks++; if (wecnt != 0)          begin errors++; $display("FAIL rd_we_pulses got %0d exp 0", wecnt); end
        checks++; if (held !== 1'b1)       begin errors++; $display("FAIL rd_ok_held got %b exp 1", held); end
        checks++; if (ok_after !== 1'b0)   begin errors++; $display("FAIL rd_ok_release got %b exp 0", ok_after); end
        cpu_cycle(1'b1, 11'h123, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (rd !== 16'hA5A5)     begin errors++; $display("FAIL rd_untouched got %h exp a5a5", rd); end
    endtask

    task automatic test_byte_write();
        cpu_cycle(1'b0, 11'h010, 16'h5566, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        cpu_cycle(1'b0, 11'h010, 16'hABCD, 2'b10, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (we1 !== 2'b01)       begin errors++; $display("FAIL bw_lo_we got %b exp 01", we1); end
        cpu_cycle(1'b1, 11'h010, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (rd !== 16'h55CD)     begin errors++; $display("FAIL bw_lo_data got %h exp 55cd", rd); end
        cpu_cycle(1'b0, 11'h010, 16'h9911, 2'b01, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (we1 !== 2'b10)       begin errors++; $display("FAIL bw_hi_we got %b exp 10", we1); end
        cpu_cycle(1'b1, 11'h010, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (rd !== 16'h99CD)     begin errors++; $display("FAIL bw_hi_data got %h exp 99cd", rd); end
    endtask

    task automatic test_null_write();
        cpu_cycle(1'b0, 11'h155, 16'hFFFF, 2'b11, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (lat != 2)            begin errors++; $display("FAIL nw_latency got %0d exp 2", lat); end
        checks++; if (wecnt != 0)          begin errors++; $display("FAIL nw_we_pulses got %0d exp 0", wecnt); end
        cpu_cycle(1'b1, 11'h155, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (rd !== 16'h1234)     begin errors++; $display("FAIL nw_data got %h exp 1234", rd); end
    endtask

    task automatic test_back_to_back();
        cpu_cycle(1'b0, 11'h7FF, 16'hBEEF, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        cpu_cycle(1'b0, 11'h000, 16'h0F0F, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (lat != 2)            begin errors++; $display("FAIL b2b_wr_latency got %0d exp 2", lat); end
        cpu_cycle(1'b1, 11'h7FF, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (rd !== 16'hBEEF)     begin errors++; $display("FAIL b2b_rd_top got %h exp beef", rd); end
        cpu_cycle(1'b1, 11'h000, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (rd !== 16'h0F0F)     begin errors++; $display("FAIL b2b_rd_bottom got %h exp 0f0f", rd); end
    endtask

`ifdef JTS16_PAL_CLR_EN
    task automatic pulse_clr();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    // Waits for clr_busy to fall; returns high cycles seen, -1 on timeout.
    task automatic wait_sweep(output int cyc);
        cyc = 0;
        while (clr_busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (clr_busy) cyc = -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_sweep_log(input string tag);
        int bad = 0;
        for (int i = 0; i < 2048; i++)
            if (wcnt[i] != 1 || mem[i] !== 16'h0000) bad++;
        checks++; if (bad != 0)        begin errors++; $display("FAIL %s_entries bad %0d exp 0", tag, bad); end
        checks++; if (seq_err != 0)    begin errors++; $display("FAIL %s_order breaks %0d exp 0", tag, seq_err); end
        checks++; if (total_writes != 2048) begin errors++; $display("FAIL %s_writes got %0d exp 2048", tag, total_writes); end
    endtask

    task automatic test_sweep();
        int cyc;
        reset_log();
        pulse_clr();
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL sw_busy_start got %b exp 1", clr_busy); end
        wait_sweep(cyc);
        checks++; if (cyc < 2048 || cyc > 2056) begin errors++; $display("FAIL sw_busy_cycles got %0d exp 2048..2056", cyc); end
        check_sweep_log("sw");
    endtask

    task automatic test_sweep_pause();
        int cyc = 0;
        cpu_cycle(1'b0, 11'h700, 16'h7777, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        reset_log();
        pulse_clr();
        while (!(ram_we == 2'b11 && ram_addr == 11'h300) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 3000) begin errors++; $display("FAIL sp_reach_300 cycles %0d exp <3000", cyc); end
        cpu_cycle(1'b1, 11'h700, 16'h0000, 2'b00, lat, rd, we1, a1, d1, wecnt, held, ok_after);
        checks++; if (rd !== 16'h7777)   begin errors++; $display("FAIL sp_rd_data got %h exp 7777", rd); end
        checks++; if (lat < 3 || lat > 5) begin errors++; $display("FAIL sp_rd_latency got %0d exp 3..5", lat); end
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL sp_busy_paused got %b exp 1", clr_busy); end
        wait_sweep(cyc);
        checks++; if (cyc < 0)           begin errors++; $display("FAIL sp_busy_timeout got %0d exp >=0", cyc); end
        check_sweep_log("sp");
    endtask

    task automatic test_reset_mid_sweep();
        pulse_clr();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ram_we !== 2'b00)  begin errors++; $display("FAIL rs_ram_we got %b exp 00", ram_we); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rs_busy got %b exp 0", clr_busy); end
        @(negedge clk);
        rst = 1'b0;
        reset_log();
        repeat (50) @(negedge clk);
        checks++; if (total_writes != 0) begin errors++; $display("FAIL rs_writes got %0d exp 0", total_writes); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rs_busy_after got %b exp 0", clr_busy); end
    endtask
`else
    task automatic test_clr_ignored();
        logic seen = 1'b0;
        reset_log();
        clr_req = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (clr_busy !== 1'b0) seen = 1'b1;
            clr_req = 1'b0;
        end
        checks++; if (seen !== 1'b0)     begin errors++; $display("FAIL ci_busy got %b exp 0", seen); end
        checks++; if (total_writes != 0) begin errors++; $display("FAIL ci_writes got %0d exp 0", total_writes); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_full();
        test_read();
        test_byte_write();
        test_null_write();
        test_back_to_back();
`ifdef JTS16_PAL_CLR_EN
        test_sweep();
        test_sweep_pause();
        test_reset_mid_sweep();
`else
        test_clr_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
